// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, 1-cycle-latency imem requests and a prefetch FIFO feeding IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       resetn,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic [31:0]                inst_out,
    output logic [31:0]                pc_out,
    output logic                       inst_valid,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_flushed,
`endif
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
    logic [31:0]   fetch_pc_q;
    logic          inflight_q;
    logic [31:0]   inflight_pc_q;
    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   inst_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;
    // Credit covers both queued entries and the response still on its way back.
    assign occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign issue      = !redirect && (occupancy < LIMIT);
    assign push       = inflight_q && !redirect;
    assign pop        = inst_valid && !stall && !redirect;
    assign imem_req   = issue;
    assign imem_addr  = fetch_pc_q;
    assign inst_valid = count_q != '0;
    assign inst_out   = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
    assign pc_out     = inst_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign count      = count_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc_q <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + 32'd4;
            end
            if (push) begin
                pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
                inst_mem_q[wr_ptr_q] <= imem_rdata;
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            if (push)
                perf_fetched_q <= perf_fetched_q + 32'd1;
            if (redirect)
                perf_flushed_q <= perf_flushed_q + 32'(occupancy);
        end
    end
    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif
    // A push into a full queue would mean the credit rule is broken.
    overflow_a: assert property (@(posedge clock) disable iff (!resetn)
        !(push && !pop && count_q == LIMIT[CW-1:0]));
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with memory returning address as data.
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        resetn;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, inst_valid;
    logic [31:0] imem_addr, imem_rdata, inst_out, pc_out;
    logic [2:0]  count;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_inst, w_pc;
    logic [2:0]  w_count;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, w_pf, w_pfl;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) imem_rdata <= imem_addr;
    always @(posedge clock) w_rdata <= w_addr;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clock(clock), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .inst_out(inst_out), .pc_out(pc_out),
        .inst_valid(inst_valid), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
        .count(count));

    fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clock(clock), .resetn(resetn), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .inst_out(w_inst), .pc_out(w_pc),
        .inst_valid(w_valid), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0),
`ifdef FETCH_PERF_EN
        .perf_fetched(w_pf), .perf_flushed(w_pfl),
`endif
        .count(w_count));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    initial begin
        resetn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst_out, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_addr", imem_addr, 0);
        @(negedge clock); resetn = 1'b1; #1;
        chk("rel_req", 32'(imem_req), 1);
        chk("rel_addr", imem_addr, 0);
        tick();
        chk("fill_valid", 32'(inst_valid), 0);
        chk("fill_addr", imem_addr, 32'h4);
        tick();
        chk("first_valid", 32'(inst_valid), 1);
        chk("first_pc", pc_out, 0);
        chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("stream_pc", pc_out, 32'(4 * i));
            chk("stream_inst", inst_out, 32'(4 * i));
            chk("stream_count", 32'(count), 1);
            if (i == 1) chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
            if (i == 2) chk("wrap_pc2", w_pc, 32'h0);
            if (i == 2) chk("wrap_inst2", w_inst, 32'h0);
        end
        #3; resetn = 1'b0; #1;
        chk("async_count", 32'(count), 0);
        chk("async_valid", 32'(inst_valid), 0);
        chk("async_addr", imem_addr, 0);
        stall = 1'b1;
        @(negedge clock); resetn = 1'b1;
        tick(10);
        chk("full_count", 32'(count), 4);
        chk("full_req", 32'(imem_req), 0);
        chk("full_pc", pc_out, 0);
        stall = 1'b0;
        tick(); chk("drain1_pc", pc_out, 32'h4);  chk("drain1_cnt", 32'(count), 3);
        tick(); chk("drain2_pc", pc_out, 32'h8);  chk("drain2_cnt", 32'(count), 2);
        tick(); chk("drain3_pc", pc_out, 32'hC);  chk("drain3_cnt", 32'(count), 2);
        stall = 1'b1;
        tick(); chk("hold_pc", pc_out, 32'hC);    chk("hold_cnt", 32'(count), 3);
        chk("hold_req", 32'(imem_req), 0);
        redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
        chk("redir_req", 32'(imem_req), 0);
        tick();
        redirect = 1'b0; stall = 1'b0; #1;
        chk("redir_count", 32'(count), 0);
        chk("redir_valid", 32'(inst_valid), 0);
        chk("redir_addr", imem_addr, 32'h100);
        chk("redir_req1", 32'(imem_req), 1);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 6);
        chk("perf_flushed", perf_flushed, 4);
`endif
        tick(); chk("redir_n2_valid", 32'(inst_valid), 0);
        tick(); chk("redir_n3_valid", 32'(inst_valid), 1);
        chk("redir_n3_pc", pc_out, 32'h100);
        chk("redir_n3_inst", inst_out, 32'h100);
        tick(); chk("redir_n4_pc", pc_out, 32'h104);
        stall = 1'b1;
        tick(8);
        chk("refull_count", 32'(count), 4);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0; #1;
        chk("rs_count", 32'(count), 0);
        chk("rs_valid", 32'(inst_valid), 0);
        chk("rs_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
        chk("perf_flushed2", perf_flushed, 8);
`endif
        stall = 1'b0;
        tick(2);
        chk("rs_pc", pc_out, 32'h200);
        tick(2);
        #1; resetn = 1'b0; #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_addr", imem_addr, 0);
        @(negedge clock); resetn = 1'b1;
        tick(2);
        chk("restart_pc", pc_out, 0);
        chk("restart_valid", 32'(inst_valid), 1);
        tick();
        chk("restart_pc1", pc_out, 32'h4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
